// File: rtl/reaction_stopwatch_pkg.sv
// Shared timing definitions for the stopwatch timer blocks.
// State encodings and default clock/limit values.
package reaction_stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        DONE    = 2'd2
    } sw_state_t;

    localparam int CLKS_PER_MS_DEFAULT = 50000;
    localparam int MAX_MS_DEFAULT      = 9999;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts clocks while run is high and
// flags the last clock of each millisecond with a one-cycle tick.
module ms_tick_gen
    import reaction_stopwatch_pkg::*;
#(
    parameter int CLKS_PER_MS = CLKS_PER_MS_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int PW = $clog2(CLKS_PER_MS + 1);
    localparam logic [PW-1:0] TOP = PW'(CLKS_PER_MS - 1);

    logic [PW-1:0] cnt;

    // Free-running divider, held at zero whenever not running.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!run) begin
            cnt <= '0;
        end else if (cnt == TOP) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PW'(1);
        end
    end

    assign tick = run && (cnt == TOP);

endmodule

// File: rtl/reaction_stopwatch.sv
// Reaction-time stopwatch: start/stop measurement in whole
// milliseconds, saturating at MAX_MS with an overflow flag.
module reaction_stopwatch
    import reaction_stopwatch_pkg::*;
#(
    parameter int CLKS_PER_MS = CLKS_PER_MS_DEFAULT,
    parameter int MAX_MS      = MAX_MS_DEFAULT,
    localparam int W          = $clog2(MAX_MS + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
    input  logic         clear,
    output logic         busy,
    output logic         valid,
    output logic         overflow,
    output logic [W-1:0] elapsed_ms
);

    localparam logic [W-1:0] MS_LAST = W'(MAX_MS - 1);
    localparam logic [W-1:0] MS_MAX  = W'(MAX_MS);

    sw_state_t    state;
    logic [W-1:0] ms_cnt;
    logic         tick;
    logic         run;

    // A clear on the same edge must also zero the prescaler.
    assign run = (state == RUNNING) && !clear;

    ms_tick_gen #(
        .CLKS_PER_MS(CLKS_PER_MS)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .run  (run),
        .tick (tick)
    );

    // Control FSM with ms counter and registered result outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ms_cnt     <= '0;
            elapsed_ms <= '0;
            busy       <= 1'b0;
            valid      <= 1'b0;
            overflow   <= 1'b0;
        end else if (clear) begin
            state      <= IDLE;
            ms_cnt     <= '0;
            elapsed_ms <= '0;
            busy       <= 1'b0;
            valid      <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= RUNNING;
                        ms_cnt   <= '0;
                        busy     <= 1'b1;
                        valid    <= 1'b0;
                        overflow <= 1'b0;
                    end
                end
                RUNNING: begin
                    if (stop) begin
                        state      <= DONE;
                        elapsed_ms <= ms_cnt;
                        busy       <= 1'b0;
                        valid      <= 1'b1;
                        overflow   <= 1'b0;
                    end else if (tick) begin
                        if (ms_cnt == MS_LAST) begin
                            state      <= DONE;
                            ms_cnt     <= MS_MAX;
                            elapsed_ms <= MS_MAX;
                            busy       <= 1'b0;
                            valid      <= 1'b1;
                            overflow   <= 1'b1;
                        end else begin
                            ms_cnt <= ms_cnt + W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reaction_stopwatch.sv
// Randomized and directed bench for reaction_stopwatch against
// a cycle-count reference model (CLKS_PER_MS=3, MAX_MS=5).
module tb_reaction_stopwatch;

    localparam int CLKS = 3;
    localparam int MAXM = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clear = 1'b0;
    logic       busy;
    logic       valid;
    logic       overflow;
    logic [2:0] elapsed_ms;

    int n_vec = 0;
    int n_err = 0;

    // model: phase 0 idle, 1 running, 2 done
    int m_phase;
    int m_k;
    int m_el;
    bit m_valid;
    bit m_ovf;
    bit m_el_known;

    reaction_stopwatch #(
        .CLKS_PER_MS(CLKS),
        .MAX_MS     (MAXM)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
        .busy      (busy),
        .valid     (valid),
        .overflow  (overflow),
        .elapsed_ms(elapsed_ms)
    );

    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase    = 0;
        m_k        = 0;
        m_el       = 0;
        m_valid    = 0;
        m_ovf      = 0;
        m_el_known = 1;
    endtask

    // k counts edges since the start edge; ms = floor(k / CLKS)
    task automatic model_edge(input bit s, input bit p, input bit c);
        if (c) begin
            model_reset();
        end else if (m_phase != 1) begin
            if (s) begin
                m_phase    = 1;
                m_k        = 0;
                m_valid    = 0;
                m_ovf      = 0;
                m_el_known = 0;
            end
        end else begin
            m_k++;
            if (p) begin
                m_el       = (m_k - 1) / CLKS;
                m_valid    = 1;
                m_ovf      = 0;
                m_phase    = 2;
                m_el_known = 1;
            end else if (m_k / CLKS >= MAXM) begin
                m_el       = MAXM;
                m_valid    = 1;
                m_ovf      = 1;
                m_phase    = 2;
                m_el_known = 1;
            end
        end
    endtask

    task automatic check_model();
        expect_eq("busy", int'(busy), int'(m_phase == 1));
        expect_eq("valid", int'(valid), int'(m_valid));
        expect_eq("overflow", int'(overflow), int'(m_ovf));
        if (m_el_known)
            expect_eq("elapsed", int'(elapsed_ms), m_el);
    endtask

    task automatic step(input bit s, input bit p, input bit c);
        start = s;
        stop  = p;
        clear = c;
        @(posedge clk);
        model_edge(s, p, c);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
        check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        model_reset();
        expect_eq("rst_busy", int'(busy), 0);
        expect_eq("rst_valid", int'(valid), 0);
        expect_eq("rst_ovf", int'(overflow), 0);
        expect_eq("rst_el", int'(elapsed_ms), 0);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        #12;
        expect_eq("por_busy", int'(busy), 0);
        expect_eq("por_valid", int'(valid), 0);
        expect_eq("por_ovf", int'(overflow), 0);
        expect_eq("por_el", int'(elapsed_ms), 0);
        reset = 1'b1;

        // start on first edge after release, stop at N+8
        step(1, 0, 0);
        expect_eq("start_busy", int'(busy), 1);
        idle(7);
        step(0, 1, 0);
        expect_eq("stop8_el", int'(elapsed_ms), 2);
        expect_eq("stop8_valid", int'(valid), 1);
        expect_eq("stop8_busy", int'(busy), 0);
        idle(3);
        expect_eq("hold_el", int'(elapsed_ms), 2);

        // restart from DONE, stop at N+2
        step(1, 0, 0);
        expect_eq("restart_valid", int'(valid), 0);
        expect_eq("restart_busy", int'(busy), 1);
        step(0, 0, 0);
        step(0, 1, 0);
        expect_eq("stop2_el", int'(elapsed_ms), 0);

        // saturation with no stop
        step(1, 0, 0);
        idle(14);
        expect_eq("presat_busy", int'(busy), 1);
        step(0, 0, 0);
        expect_eq("sat_el", int'(elapsed_ms), 5);
        expect_eq("sat_ovf", int'(overflow), 1);
        expect_eq("sat_busy", int'(busy), 0);

        // stop coincides with saturation
        step(1, 0, 0);
        idle(14);
        step(0, 1, 0);
        expect_eq("stop15_el", int'(elapsed_ms), 4);
        expect_eq("stop15_ovf", int'(overflow), 0);

        // start while running is ignored
        step(1, 0, 0);
        idle(3);
        step(1, 0, 0);
        idle(3);
        step(0, 1, 0);
        expect_eq("ign_start_el", int'(elapsed_ms), 2);

        // async reset mid-measurement
        step(1, 0, 0);
        idle(5);
        pulse_reset();
        idle(3);
        expect_eq("post_rst_valid", int'(valid), 0);

        // stop in IDLE ignored; start+stop in IDLE starts
        step(0, 1, 0);
        step(1, 1, 0);
        expect_eq("ss_busy", int'(busy), 1);
        idle(4);
        step(1, 1, 0);
        expect_eq("ss_run_el", int'(elapsed_ms), 1);

        // clear in DONE
        step(0, 0, 1);
        expect_eq("clr_valid", int'(valid), 0);
        expect_eq("clr_el", int'(elapsed_ms), 0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                pulse_reset();
            end else begin
                step($urandom_range(0, 99) < 12,
                     $urandom_range(0, 99) < 6,
                     $urandom_range(0, 99) < 2);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reaction_stopwatch.md
REACTION_STOPWATCH -- requirements
Module: reaction_stopwatch

Interface
REQ-001 SHALL have parameter CLKS_PER_MS, default 50000, giving clock cycles per millisecond (50 MHz clock).
REQ-002 SHALL have parameter MAX_MS, default 9999, giving the saturation limit of the millisecond count.
REQ-003 SHALL have derived localparam W = $clog2(MAX_MS+1), the width of elapsed_ms.
REQ-004 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  single-cycle request to begin a measurement.
REQ-007 SHALL have port stop  input  1  single-cycle request to end a measurement.
REQ-008 SHALL have port clear  input  1  synchronous abort; returns the block to IDLE.
REQ-009 SHALL have port busy  output  1  high while a measurement is running.
REQ-010 SHALL have port valid  output  1  high while elapsed_ms holds a completed result.
REQ-011 SHALL have port overflow  output  1  high when the result saturated at MAX_MS.
REQ-012 SHALL have port elapsed_ms  output  W  measured whole milliseconds.

Function
REQ-013 SHALL implement an FSM with the states IDLE, RUNNING and DONE; all outputs SHALL be registered.
REQ-014 SHALL, in IDLE or DONE with start=1, clear the prescaler, ms count, valid and overflow, and enter RUNNING at that edge.
REQ-015 SHALL, in RUNNING, increment the prescaler on every edge; on an edge where prescaler == CLKS_PER_MS-1, reset the prescaler to 0 and increment the ms count.
REQ-016 SHALL, in RUNNING with stop=1, latch elapsed_ms = ms count register value before that edge's increment, set valid=1 and overflow=0, and enter DONE.
REQ-017 SHALL, when a ms increment would make ms count equal MAX_MS and stop=0, latch elapsed_ms=MAX_MS, set valid=1 and overflow=1, and enter DONE.
REQ-018 SHALL give stop priority over saturation when both occur on the same edge (result MAX_MS-1, overflow=0).
REQ-019 SHALL ignore start while in RUNNING.
REQ-020 SHALL ignore stop while in IDLE or DONE.
REQ-021 SHALL, when start=1 and stop=1 on the same edge, let start win in IDLE/DONE and stop win in RUNNING.
REQ-022 SHALL hold elapsed_ms, valid and overflow stable throughout DONE until the next start or clear.
REQ-023 SHALL drive busy=1 exactly while in RUNNING.
REQ-024 SHALL give clear priority over start and stop: next state IDLE, prescaler=0, ms count=0, elapsed_ms=0, valid=0, overflow=0.
REQ-025 SHALL never let the ms count exceed MAX_MS or wrap around.
REQ-026 SHALL never let the prescaler exceed CLKS_PER_MS-1.

Reset
REQ-027 SHALL, on reset=0 and independent of clk, force state=IDLE, prescaler=0, ms count=0, elapsed_ms=0, busy=0, valid=0 and overflow=0.
REQ-028 SHALL, when reset is asserted mid-measurement, discard the measurement, with no valid pulse after release.
REQ-029 SHALL, on the first edge after reset release, behave as IDLE; a start sampled on that edge SHALL be honoured.

Structure
REQ-030 SHALL place the FSM state encodings (IDLE=2'd0, RUNNING=2'd1, DONE=2'd2) and the default CLKS_PER_MS/MAX_MS values in the shared timing package/header used by the timer blocks.
REQ-031 SHALL implement the prescaler as one sub-module, ms_tick_gen (inputs clk, reset, run; output a one-cycle tick), with its counter cleared whenever run=0.
REQ-032 SHALL keep the FSM, the ms counter and the result latch in reaction_stopwatch.

Verification (CLKS_PER_MS=3, MAX_MS=5; start sampled at edge N)
REQ-033 SHALL cover: stop sampled at edge N+8 -> elapsed_ms=2, valid=1, overflow=0, busy=0 after N+8.
REQ-034 SHALL cover: no stop -> at edge N+15 elapsed_ms=5, overflow=1, valid=1, busy falls.
REQ-035 SHALL cover: stop at edge N+15 -> elapsed_ms=4, overflow=0.
REQ-036 SHALL cover: start at N+4 while RUNNING, then stop at N+8 -> elapsed_ms=2 (start ignored).
REQ-037 SHALL cover: valid result held, then start -> valid=0 next cycle, busy=1; stop at N+2 -> elapsed_ms=0.
REQ-038 SHALL cover: reset pulsed low between edges at N+5 -> all outputs 0 immediately; clear in DONE -> IDLE, outputs 0.
